// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR control register block: register map,
// CTRL/STATUS bit positions, sequencer state encoding and kernel geometry.
package fir_ctrl_pkg;

    // 3x3 signed kernel, 16 bits per tap
    localparam int COEF_W = 16;
    localparam int COEF_N = 9;

    // Frame dimension register width
    localparam int DIM_W = 12;

    // Register byte offsets
    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_WIDTH   = 8'h08;
    localparam logic [7:0] OFF_HEIGHT  = 8'h0C;
    localparam logic [7:0] OFF_COEF0   = 8'h10;
    localparam logic [7:0] OFF_PIX_CNT = 8'h34;

    // CTRL bit indices
    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit indices
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    // Byte offset of coefficient register k (COEF0..COEF8 are word-spaced)
    function automatic logic [7:0] coef_off(input int k);
        return OFF_COEF0 + 8'(4 * k);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Nine-entry kernel coefficient store. Byte-strobed writes from the register
// port; all writes are dropped while lock_i is high so the datapath sees a
// constant kernel for the whole frame.
module fir_coef_bank
    import fir_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [ADDR_BITS-1:0]       wr_addr_i,
    input  logic [15:0]                wr_data_i,
    input  logic [1:0]                 wr_strb_i,
    input  logic                       lock_i,
    output logic [COEF_N*COEF_W-1:0]   coef_o
);

    logic [COEF_W-1:0] coef_q [COEF_N];
    logic [COEF_W-1:0] coef_d [COEF_N];

    // Next-state: merge enabled bytes into the addressed tap when unlocked
    always_comb begin
        for (int k = 0; k < COEF_N; k++) begin
            coef_d[k] = coef_q[k];
            if (wr_en_i && !lock_i && (wr_addr_i == ADDR_BITS'(coef_off(k)))) begin
                if (wr_strb_i[0]) coef_d[k][7:0]  = wr_data_i[7:0];
                if (wr_strb_i[1]) coef_d[k][15:8] = wr_data_i[15:8];
            end
        end
    end

    // Tap registers, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < COEF_N; k++) coef_q[k] <= '0;
        end else begin
            for (int k = 0; k < COEF_N; k++) coef_q[k] <= coef_d[k];
        end
    end

    // Pack taps row-major, tap 0 (top-left) in the least significant slot
    always_comb begin
        coef_o = '0;
        for (int k = 0; k < COEF_N; k++) coef_o[k*COEF_W +: COEF_W] = coef_q[k];
    end

endmodule

// File: rtl/fir_ctrl_regs.sv
// FIR filter control/status register block and frame sequencer.
// Register port: a write takes effect on the clock edge where wr_en is high
// (single-cycle strobe, no back-pressure); reads are combinational from
// rd_addr and have no side effects, rd_en is informational only.
// Optional feature macro: FIR_CTRL_IRQ_EN enables the stored IRQ_EN bit and
// the registered level interrupt irq = DONE & IRQ_EN; otherwise irq is 0.
module fir_ctrl_regs
    import fir_ctrl_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int PIX_CNT_BITS = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_BITS-1:0]      wr_addr,
    input  logic                      wr_en,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strb,
    input  logic [ADDR_BITS-1:0]      rd_addr,
    input  logic                      rd_en,
    output logic [31:0]               rd_data,
    output logic [COEF_N*COEF_W-1:0]  coef,
    output logic                      frame_start,
    output logic                      run,
    input  logic                      pix_valid,
    output logic                      frame_done,
    output logic                      irq,
    output logic [1:0]                state_dbg
);

    localparam logic [ADDR_BITS-1:0] A_CTRL    = ADDR_BITS'(OFF_CTRL);
    localparam logic [ADDR_BITS-1:0] A_STATUS  = ADDR_BITS'(OFF_STATUS);
    localparam logic [ADDR_BITS-1:0] A_WIDTH   = ADDR_BITS'(OFF_WIDTH);
    localparam logic [ADDR_BITS-1:0] A_HEIGHT  = ADDR_BITS'(OFF_HEIGHT);
    localparam logic [ADDR_BITS-1:0] A_PIX_CNT = ADDR_BITS'(OFF_PIX_CNT);

    fsm_state_e              state_q;
    logic                    frame_start_q, run_q, frame_done_q;
    logic                    done_q, err_q;
    logic [DIM_W-1:0]        width_q, width_d;
    logic [DIM_W-1:0]        height_q, height_d;
    logic [PIX_CNT_BITS-1:0] total_q, pix_cnt_q, pix_cnt_inc;
    logic                    irq_en_rd;

    // Write decode
    logic ctrl_wr, stat_wr, start_req, abort_req;
    logic done_clr, err_clr, done_set, err_set;
    logic cfg_lock, dims_ok;

    assign ctrl_wr   = wr_en && (wr_addr == A_CTRL) && wr_strb[0];
    assign stat_wr   = wr_en && (wr_addr == A_STATUS) && wr_strb[0];
    // ABORT wins over START in the same write; the START is simply dropped
    assign abort_req = ctrl_wr && wr_data[CTRL_ABORT];
    assign start_req = ctrl_wr && wr_data[CTRL_START] && !wr_data[CTRL_ABORT];
    assign done_clr  = stat_wr && wr_data[STAT_DONE];
    assign err_clr   = stat_wr && wr_data[STAT_ERR];

    // Configuration is frozen from ARM through DONE so the kernel and the
    // frame size cannot change under an active frame
    assign cfg_lock  = (state_q != ST_IDLE);
    assign dims_ok   = (width_q != '0) && (height_q != '0);
    assign err_set   = start_req && ((state_q != ST_IDLE) || !dims_ok);
    assign done_set  = (state_q == ST_DONE);
    assign pix_cnt_inc = pix_cnt_q + PIX_CNT_BITS'(1);

    // Byte-strobed frame dimension next-state, ignored while locked
    always_comb begin
        width_d  = width_q;
        height_d = height_q;
        if (wr_en && !cfg_lock && (wr_addr == A_WIDTH)) begin
            if (wr_strb[0]) width_d[7:0]  = wr_data[7:0];
            if (wr_strb[1]) width_d[11:8] = wr_data[11:8];
        end
        if (wr_en && !cfg_lock && (wr_addr == A_HEIGHT)) begin
            if (wr_strb[0]) height_d[7:0]  = wr_data[7:0];
            if (wr_strb[1]) height_d[11:8] = wr_data[11:8];
        end
    end

    // Dimension and sticky status registers; a set beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q  <= '0;
            height_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            width_q  <= width_d;
            height_q <= height_d;
            done_q   <= done_set | (done_q & ~done_clr);
            err_q    <= err_set  | (err_q  & ~err_clr);
        end
    end

    // Frame sequencer with registered frame_start / run / frame_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            frame_start_q <= 1'b0;
            run_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            total_q       <= '0;
            pix_cnt_q     <= '0;
        end else begin
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_req && dims_ok) begin
                        state_q       <= ST_ARM;
                        frame_start_q <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (abort_req) begin
                        state_q <= ST_IDLE;
                    end else begin
                        total_q   <= PIX_CNT_BITS'(width_q) * PIX_CNT_BITS'(height_q);
                        pix_cnt_q <= '0;
                        run_q     <= 1'b1;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_req) begin
                        run_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (pix_valid) begin
                        pix_cnt_q <= pix_cnt_inc;
                        if (pix_cnt_inc == total_q) begin
                            run_q        <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_CTRL_IRQ_EN
    logic irq_en_q, irq_q;

    // IRQ enable bit and registered level interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= wr_data[CTRL_IRQ_EN];
            irq_q <= done_q & irq_en_q;
        end
    end

    assign irq_en_rd = irq_en_q;
    assign irq       = irq_q;
`else
    assign irq_en_rd = 1'b0;
    assign irq       = 1'b0;
`endif

    fir_coef_bank #(
        .ADDR_BITS (ADDR_BITS)
    ) u_coef_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data[15:0]),
        .wr_strb_i (wr_strb[1:0]),
        .lock_i    (cfg_lock),
        .coef_o    (coef)
    );

    // Combinational read mux; unmapped addresses read zero
    always_comb begin
        rd_data = '0;
        if (rd_addr == A_CTRL) begin
            rd_data[CTRL_IRQ_EN] = irq_en_rd;
        end else if (rd_addr == A_STATUS) begin
            rd_data[STAT_BUSY] = run_q;
            rd_data[STAT_DONE] = done_q;
            rd_data[STAT_ERR]  = err_q;
        end else if (rd_addr == A_WIDTH) begin
            rd_data[DIM_W-1:0] = width_q;
        end else if (rd_addr == A_HEIGHT) begin
            rd_data[DIM_W-1:0] = height_q;
        end else if (rd_addr == A_PIX_CNT) begin
            rd_data = 32'(pix_cnt_q);
        end
        for (int k = 0; k < COEF_N; k++) begin
            if (rd_addr == ADDR_BITS'(coef_off(k))) rd_data[COEF_W-1:0] = coef[k*COEF_W +: COEF_W];
        end
    end

    assign frame_start = frame_start_q;
    assign run         = run_q;
    assign frame_done  = frame_done_q;
    assign state_dbg   = state_q;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, rd_en, wr_data[31:16], wr_strb[3:2]};

endmodule

// File: doc/fir_ctrl_regs.md
FIR_CTRL_REGS -- requirements
Module: fir_ctrl_regs

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, register-port address width (byte address).
REQ-002 SHALL have parameter PIX_CNT_BITS, default 24, width of the frame pixel counter.
REQ-003 SHALL have clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have wr_addr  input  ADDR_BITS  register write byte address.
REQ-006 SHALL have wr_en  input  1  one-cycle write strobe.
REQ-007 SHALL have wr_data  input  32  write data.
REQ-008 SHALL have wr_strb  input  4  byte enables for wr_data.
REQ-009 SHALL have rd_addr  input  ADDR_BITS  register read byte address.
REQ-010 SHALL have rd_en  input  1  read strobe, informational only.
REQ-011 SHALL have rd_data  output  32  read data, combinational from rd_addr.
REQ-012 SHALL have coef  output  9x16  3x3 signed kernel, row-major, coef[0] top-left.
REQ-013 SHALL have frame_start  output  1  one-cycle pulse starting datapath.
REQ-014 SHALL have run  output  1  high while frame in progress.
REQ-015 SHALL have pix_valid  input  1  datapath produced one output pixel this cycle.
REQ-016 SHALL have frame_done  output  1  one-cycle pulse at frame completion.
REQ-017 SHALL have irq  output  1  level interrupt.

Function
REQ-018 SHALL decode registers at 0x00 CTRL, 0x04 STATUS, 0x08 WIDTH[11:0], 0x0C HEIGHT[11:0], 0x10-0x30 COEF0-COEF8[15:0], 0x34 PIX_CNT (RO); all others read 0, writes ignored.
REQ-019 SHALL implement CTRL bit0 START and bit1 ABORT as write-1 self-clearing (read 0), bit2 IRQ_EN as R/W; CTRL acts only when wr_strb[0]=1.
REQ-020 SHALL implement STATUS bit0 BUSY (RO, =run), bit1 DONE sticky W1C, bit2 ERR sticky W1C.
REQ-021 SHALL apply wr_strb per byte to WIDTH, HEIGHT, COEF; unused upper bits read 0.
REQ-022 SHALL ignore writes to WIDTH, HEIGHT, COEF while BUSY; coef stays stable for the whole frame.
REQ-023 SHALL have read no side effects; rd_data valid in the same cycle rd_addr is stable.
REQ-024 SHALL implement FSM IDLE -> ARM -> RUN -> DONE -> IDLE.
REQ-025 IDLE: START with WIDTH!=0 and HEIGHT!=0 -> ARM next cycle; START with either zero -> stay IDLE, set ERR.
REQ-026 ARM: latch total=WIDTH*HEIGHT (PIX_CNT_BITS wide), clear PIX_CNT, assert frame_start for this one cycle, -> RUN.
REQ-027 RUN: run=1; each pix_valid increments PIX_CNT; pix_valid bringing PIX_CNT to total -> DONE.
REQ-028 DONE: frame_done=1 for this cycle, set DONE sticky, -> IDLE; run=0.
REQ-029 START while not IDLE SHALL be ignored and set ERR.
REQ-030 ABORT in ARM or RUN SHALL go to IDLE next cycle, no frame_done, DONE unchanged, PIX_CNT holds.
REQ-031 START and ABORT in the same write: ABORT wins, START discarded without ERR.
REQ-032 Set and W1C of DONE or ERR in the same cycle: set wins.
REQ-033 pix_valid outside RUN SHALL be ignored.

Reset
REQ-034 On rst: FSM IDLE, CTRL, STATUS, WIDTH, HEIGHT, PIX_CNT, all COEF =0; frame_start, run, frame_done, irq =0; rst mid-frame aborts without frame_done.

Configuration
REQ-035 With FIR_CTRL_IRQ_EN defined: irq = DONE & IRQ_EN, registered; without it: irq tied 0, IRQ_EN bit not stored, reads 0.

Structure
REQ-036 Package fir_ctrl_pkg SHALL hold register offsets, CTRL/STATUS bit indices, FSM state encoding, coefficient width and count.
REQ-037 Coefficient storage with strobe/lock logic SHALL be sub-module fir_coef_bank; sequencer and decode stay in fir_ctrl_regs.

Verification
REQ-038 WIDTH=4, HEIGHT=2, START -> frame_start one cycle later, run high, 8th pix_valid -> frame_done pulse, DONE=1, PIX_CNT=8.
REQ-039 Write COEF4=0x1234 with wr_strb=0b0001 -> coef[4]=0x0034; same write while BUSY -> unchanged.
REQ-040 WIDTH=0, START -> stays IDLE, ERR=1; write STATUS=0x4 -> ERR=0.
REQ-041 ABORT after 3 of 8 pixels -> IDLE, no frame_done, PIX_CNT=3; CTRL=0x3 in IDLE -> no frame_start.
REQ-042 FIR_CTRL_IRQ_EN, IRQ_EN=1, frame completes -> irq=1; W1C DONE -> irq=0; macro undefined -> irq=0 throughout.
REQ-043 rst asserted mid-RUN -> all outputs and registers zero next cycle, no frame_done.
